trace_dedup_buffer: RTL and testbench

- Upstream of the trace-to-index mapper.
- Takes the raw 32-bit control-flow trace stream and drops consecutive duplicate values.
- Buffers surviving values in a small FIFO.
- Presents them to the mapper over a valid/ready handshake, so mapper stalls do not lose trace data until the buffer overflows.

---
 rtl/trace_dedup_buffer.sv | 118 +++++++++++
 tb/tb_trace_dedup_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/trace_dedup_buffer.sv
// trace_dedup_buffer
//   Sits in front of the trace-to-index mapper. Drops consecutive duplicate
//   trace words, queues the survivors in a first-word-fall-through FIFO and
//   hands them out over a valid/ready handshake. The trace source has no
//   backpressure; if the FIFO is full, a non-duplicate word is lost and the
//   sticky overflow flag is set.
//
//   Optional build macro TRACE_DEDUP_STATS_EN adds dup_count / drop_count
//   (saturating 32-bit counters, cleared by reset or flush).
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   flush            synchronous clear of FIFO, dedup history and overflow
//   trace_in         raw trace word
//   trace_in_valid   trace_in is valid this cycle
//   trace_out        head-of-FIFO word (0 while empty)
//   trace_out_valid  FIFO not empty
//   trace_out_ready  mapper takes trace_out this cycle
//   fill_level       current occupancy, 0..DEPTH
//   overflow         sticky: a non-duplicate word was dropped
//   dup_count        (stats) duplicates dropped
//   drop_count       (stats) words lost to overflow
module trace_dedup_buffer #(
  parameter int DEPTH   = 16,
  parameter int TRACE_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [TRACE_W-1:0]       trace_in,
  input  logic                     trace_in_valid,
  output logic [TRACE_W-1:0]       trace_out,
  output logic                     trace_out_valid,
  input  logic                     trace_out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow
`ifdef TRACE_DEDUP_STATS_EN
  ,
  output logic [31:0]              dup_count,
  output logic [31:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  logic [TRACE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [TRACE_W-1:0] last_trace;
  logic               last_vld;

  logic dup, push, pop, full, push_ok, push_drop;

  assign dup       = trace_in_valid && last_vld && (trace_in == last_trace);
  assign push      = trace_in_valid && !dup && !flush;
  assign full      = (fill_level == FW'(DEPTH));
  assign pop       = trace_out_valid && trace_out_ready && !flush;
  // A full FIFO still accepts a word when the head leaves in the same cycle:
  // write and read pointers coincide, and the head is read before the write.
  assign push_ok   = push && (!full || pop);
  assign push_drop = push && full && !pop;

  assign trace_out_valid = (fill_level != '0);
  // Gate to zero while empty so the output is deterministic without
  // resetting the storage array.
  assign trace_out       = trace_out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= trace_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      last_trace <= '0;
      last_vld   <= 1'b0;
    end else if (flush) begin
      // last_trace is left alone; clearing last_vld is enough to stop dedup.
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
      last_vld   <= 1'b0;
    end else begin
      if (trace_in_valid) begin
        // History advances even for dropped words, so a repeat of a lost
        // word is itself treated as a duplicate.
        last_trace <= trace_in;
        last_vld   <= 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      fill_level <= fill_level + FW'(1);
      else if (pop && !push_ok) fill_level <= fill_level - FW'(1);
      if (push_drop) overflow <= 1'b1;
    end
  end

`ifdef TRACE_DEDUP_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dup_count  <= '0;
      drop_count <= '0;
    end else if (flush) begin
      dup_count  <= '0;
      drop_count <= '0;
    end else begin
      if (dup && (dup_count != 32'hFFFF_FFFF))        dup_count  <= dup_count + 32'd1;
      if (push_drop && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_dedup_buffer.sv
// Directed bench for trace_dedup_buffer (DEPTH=16, TRACE_W=32).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_trace_dedup_buffer;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] trace_in;
  logic        trace_in_valid;
  logic [31:0] trace_out;
  logic        trace_out_valid;
  logic        trace_out_ready;
  logic [4:0]  fill_level;
  logic        overflow;
`ifdef TRACE_DEDUP_STATS_EN
  logic [31:0] dup_count;
  logic [31:0] drop_count;
`endif

  int total = 0;
  int bad   = 0;

  trace_dedup_buffer #(.DEPTH(16), .TRACE_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .trace_in        (trace_in),
    .trace_in_valid  (trace_in_valid),
    .trace_out       (trace_out),
    .trace_out_valid (trace_out_valid),
    .trace_out_ready (trace_out_ready),
    .fill_level      (fill_level),
    .overflow        (overflow)
`ifdef TRACE_DEDUP_STATS_EN
    ,
    .dup_count       (dup_count),
    .drop_count      (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dd_in  [5] = '{32'h100, 32'h100, 32'h104, 32'h104, 32'h100};
  logic        dd_ev  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] dd_eo  [6] = '{32'h100, 32'h0, 32'h104, 32'h0, 32'h100, 32'h0};

  initial begin
    reset = 1'b0; flush = 1'b0; trace_in = 32'h55; trace_in_valid = 1'b1;
    trace_out_ready = 1'b0;

    // reset held with input activity
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_valid", {31'd0, trace_out_valid}, 32'd0);
      chk("rst_fill",  {27'd0, fill_level}, 32'd0);
      chk("rst_ovf",   {31'd0, overflow}, 32'd0);
      chk("rst_out",   trace_out, 32'd0);
    end

    // dedup with ready high
    reset = 1'b1; trace_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin trace_in = dd_in[i]; trace_in_valid = 1'b1; end
      else trace_in_valid = 1'b0;
      step();
      chk($sformatf("dd_valid%0d", i), {31'd0, trace_out_valid}, {31'd0, dd_ev[i]});
      chk($sformatf("dd_out%0d", i), trace_out, dd_eo[i]);
    end
`ifdef TRACE_DEDUP_STATS_EN
    chk("dd_dupcnt", dup_count, 32'd2);
`endif

    // backpressure fill to DEPTH, then one overflow
    trace_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      trace_in = 32'h10 + i; trace_in_valid = 1'b1;
      step();
    end
    chk("bp_fill16", {27'd0, fill_level}, 32'd16);
    chk("bp_noovf",  {31'd0, overflow}, 32'd0);
    trace_in = 32'h20;
    step();
    chk("bp_ovf",    {31'd0, overflow}, 32'd1);
    chk("bp_fill_k", {27'd0, fill_level}, 32'd16);
    trace_in_valid = 1'b0;
    step();
    chk("bp_hold",   trace_out, 32'h10);
    trace_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("bp_out%0d", i), trace_out, 32'h10 + i);
      step();
    end
    chk("bp_empty", {31'd0, trace_out_valid}, 32'd0);
    chk("bp_ovf_sticky", {31'd0, overflow}, 32'd1);
`ifdef TRACE_DEDUP_STATS_EN
    chk("bp_dropcnt", drop_count, 32'd1);
`endif

    // flush clears overflow; then full + simultaneous push/pop
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ovf_clr", {31'd0, overflow}, 32'd0);
    trace_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      trace_in = 32'h40 + i; trace_in_valid = 1'b1;
      step();
    end
    trace_in = 32'h30; trace_out_ready = 1'b1;
    step();
    trace_in_valid = 1'b0;
    chk("fp_fill", {27'd0, fill_level}, 32'd16);
    chk("fp_ovf",  {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fp_out%0d", i), trace_out, (i < 15) ? 32'h41 + i : 32'h30);
      step();
    end
    chk("fp_empty", {31'd0, trace_out_valid}, 32'd0);

    // flush with input present
    trace_out_ready = 1'b0;
    trace_in_valid = 1'b1;
    trace_in = 32'hA;   step();
    trace_in = 32'hB;   step();
    trace_in = 32'hABC; step();
    chk("fl_fill3", {27'd0, fill_level}, 32'd3);
    trace_in = 32'hDEF; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_fill0",  {27'd0, fill_level}, 32'd0);
    chk("fl_valid0", {31'd0, trace_out_valid}, 32'd0);
    chk("fl_ovf0",   {31'd0, overflow}, 32'd0);
    trace_in = 32'hABC;
    step();
    chk("fl_abc_fill", {27'd0, fill_level}, 32'd1);
    chk("fl_abc_out",  trace_out, 32'hABC);
    step();  // same word again is now a duplicate
    chk("fl_abc_dup", {27'd0, fill_level}, 32'd1);

    // async reset with 5 entries queued
    for (int i = 0; i < 4; i++) begin
      trace_in = 32'h61 + i;
      step();
    end
    trace_in_valid = 1'b0;
    chk("ar_fill5", {27'd0, fill_level}, 32'd5);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_valid", {31'd0, trace_out_valid}, 32'd0);
    chk("ar_fill",  {27'd0, fill_level}, 32'd0);
    step();
    reset = 1'b1; trace_in = 32'h5; trace_in_valid = 1'b1; trace_out_ready = 1'b1;
    step();
    trace_in_valid = 1'b0;
    chk("ar_out",   trace_out, 32'h5);
    chk("ar_fill1", {27'd0, fill_level}, 32'd1);
    step();
    chk("ar_drain", {31'd0, trace_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
